// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared instruction-memory widths and arbiter owner encoding
package imem_pkg;

   localparam int DEF_ADDR_W = 5;
   localparam int DEF_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      LD_RD = 2'd2,
      LD_WR = 2'd3
   } owner_e;

endpackage

// File: rtl/imem_arbiter_if.sv
// rtl/imem_arbiter_if.sv - fetch, loader and memory-port signals of the imem arbiter
interface imem_arbiter_if
   import imem_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);

   logic              fetch_req;
   logic [ADDR_W-1:0] fetch_addr;
   logic              fetch_kill;
   logic              fetch_gnt;
   logic              stall_f;
   logic              fetch_rvalid;
   logic [DATA_W-1:0] fetch_rdata;

   logic              ld_req;
   logic              ld_we;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_wdata;
   logic              ld_hold;
   logic              ld_gnt;
   logic              ld_rvalid;
   logic [DATA_W-1:0] ld_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  fetch_req, fetch_addr, fetch_kill,
      output fetch_gnt, stall_f, fetch_rvalid, fetch_rdata,
      input  ld_req, ld_we, ld_addr, ld_wdata, ld_hold,
      output ld_gnt, ld_rvalid, ld_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output fetch_req, fetch_addr, fetch_kill,
      input  fetch_gnt, stall_f, fetch_rvalid, fetch_rdata,
      output ld_req, ld_we, ld_addr, ld_wdata, ld_hold,
      input  ld_gnt, ld_rvalid, ld_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - single-port imem arbiter: fetch vs loader with bounded loader burst
module imem_arbiter
   import imem_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int MAX_LD_BURST = 4
) (
   input  logic           clk,
   input  logic           rst,
   imem_arbiter_if.slave  bus
);

   localparam logic [3:0] BURST_LIM = 4'(MAX_LD_BURST);

   owner_e     owner_q, owner_d;
   logic [3:0] streak_q, streak_d;
   logic       fetch_elig, ld_elig;
   logic       fetch_gnt, ld_gnt;

   // A killed fetch presents a wrong-path address, so it is never eligible.
   always_comb begin
      fetch_elig = bus.fetch_req & ~bus.fetch_kill & ~bus.ld_hold & ~rst;
      ld_elig    = bus.ld_req & ~rst;
      fetch_gnt  = fetch_elig & (~ld_elig | (streak_q == BURST_LIM));
      ld_gnt     = ld_elig & ~fetch_gnt;
   end

   always_comb begin
      streak_d = streak_q;
      if (fetch_gnt | ~fetch_elig) begin
         streak_d = 4'd0;
      end else if (ld_gnt && (streak_q != BURST_LIM)) begin
         streak_d = streak_q + 4'd1;
      end
   end

   always_comb begin
      owner_d = IDLE;
      if (fetch_gnt) begin
         owner_d = FETCH;
      end else if (ld_gnt) begin
         owner_d = bus.ld_we ? LD_WR : LD_RD;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_q  <= IDLE;
         streak_q <= 4'd0;
      end else begin
         owner_q  <= owner_d;
         streak_q <= streak_d;
      end
   end

   always_comb begin
      bus.fetch_gnt    = fetch_gnt;
      bus.ld_gnt       = ld_gnt;
      bus.stall_f      = bus.fetch_req & ~fetch_gnt & ~bus.fetch_kill;

      bus.mem_en       = fetch_gnt | ld_gnt;
      bus.mem_we       = ld_gnt & bus.ld_we;
      bus.mem_addr     = '0;
      bus.mem_wdata    = '0;
      if (fetch_gnt) begin
         bus.mem_addr  = bus.fetch_addr;
      end else if (ld_gnt) begin
         bus.mem_addr  = bus.ld_addr;
         bus.mem_wdata = bus.ld_wdata;
      end

      bus.fetch_rvalid = 1'b0;
      bus.fetch_rdata  = '0;
      bus.ld_rvalid    = 1'b0;
      bus.ld_rdata     = '0;
      // A kill arriving in the response cycle turns the returning fetch into a bubble.
      unique case (owner_q)
         FETCH: begin
            bus.fetch_rvalid = ~bus.fetch_kill;
            bus.fetch_rdata  = bus.fetch_kill ? '0 : bus.mem_rdata;
         end
         LD_RD: begin
            bus.ld_rvalid = 1'b1;
            bus.ld_rdata  = bus.mem_rdata;
         end
         LD_WR: begin
            bus.ld_rvalid = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - self-checking bench for imem_arbiter against a rule-level model
module tb_imem_arbiter;

   localparam int MAXB = 4;

   logic clk;
   logic rst;

   imem_arbiter_if bus ();

   imem_arbiter #(
      .ADDR_W       (5),
      .DATA_W       (32),
      .MAX_LD_BURST (MAXB)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory environment: synchronous single-port RAM, read data one cycle after mem_en.
   logic [31:0] mem [32];
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
         bus.mem_rdata <= mem[bus.mem_addr];
      end
   end

   int          n_tests = 0;
   int          n_fail  = 0;

   // Reference model state: expected memory contents, pending response, loader streak.
   logic [31:0] ref_mem [32];
   int          m_pend;     // 0 none, 1 fetch, 2 loader
   logic [31:0] m_pdata;
   int          m_streak;
   logic        last_fg, last_lg;
   string       seq;
   logic        capture;

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pend   = 0;
      m_pdata  = 32'd0;
      m_streak = 0;
      last_fg  = 1'b0;
      last_lg  = 1'b0;
   endtask

   task automatic tick();
      logic        fe, le, efg, elg, efrv, elrv;
      logic [31:0] eaddr, ewd;
      @(negedge clk);
      fe  = bus.fetch_req && !bus.fetch_kill && !bus.ld_hold && !rst;
      le  = bus.ld_req && !rst;
      efg = fe && (!le || (m_streak == MAXB));
      elg = le && !efg;
      eaddr = efg ? 32'(bus.fetch_addr) : (elg ? 32'(bus.ld_addr) : 32'd0);
      ewd   = elg ? bus.ld_wdata : 32'd0;
      efrv  = (m_pend == 1) && !bus.fetch_kill;
      elrv  = (m_pend == 2);

      check1 ("fetch_gnt",    bus.fetch_gnt,    efg);
      check1 ("ld_gnt",       bus.ld_gnt,       elg);
      check1 ("stall_f",      bus.stall_f,      bus.fetch_req && !efg && !bus.fetch_kill);
      check1 ("mem_en",       bus.mem_en,       efg || elg);
      check1 ("mem_we",       bus.mem_we,       elg && bus.ld_we);
      check32("mem_addr",     32'(bus.mem_addr), eaddr);
      check32("mem_wdata",    bus.mem_wdata,    ewd);
      check1 ("fetch_rvalid", bus.fetch_rvalid, efrv);
      check32("fetch_rdata",  bus.fetch_rdata,  efrv ? m_pdata : 32'd0);
      check1 ("ld_rvalid",    bus.ld_rvalid,    elrv);
      check32("ld_rdata",     bus.ld_rdata,     elrv ? m_pdata : 32'd0);

      if (capture) seq = {seq, efg ? "F" : (elg ? "L" : "-")};

      if (efg) begin
         m_pend  = 1;
         m_pdata = ref_mem[bus.fetch_addr];
      end else if (elg) begin
         m_pend = 2;
         if (bus.ld_we) begin
            ref_mem[bus.ld_addr] = bus.ld_wdata;
            m_pdata = 32'd0;
         end else begin
            m_pdata = ref_mem[bus.ld_addr];
         end
      end else begin
         m_pend = 0;
      end
      if (!fe || efg)                   m_streak = 0;
      else if (elg && m_streak < MAXB)  m_streak++;
      last_fg = efg;
      last_lg = elg;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.fetch_req  = 1'b0;
      bus.fetch_addr = 5'd0;
      bus.fetch_kill = 1'b0;
      bus.ld_req     = 1'b0;
      bus.ld_we      = 1'b0;
      bus.ld_addr    = 5'd0;
      bus.ld_wdata   = 32'd0;
      bus.ld_hold    = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         mem[i]     = (i < 3) ? 32'hA0 + 32'(i) : $urandom;
         ref_mem[i] = mem[i];
      end
      capture = 1'b0;
      seq     = "";
      model_reset();
      idle_inputs();

      // Reset with both requesters active: nothing may be granted.
      rst = 1'b1;
      bus.fetch_req = 1'b1;
      bus.ld_req    = 1'b1;
      @(posedge clk); #1;
      tick();
      tick();
      rst = 1'b0;
      idle_inputs();
      tick();

      // Fetch only, addresses 0,1,2.
      for (int a = 0; a < 3; a++) begin
         bus.fetch_req  = 1'b1;
         bus.fetch_addr = 5'(a);
         tick();
         check1("fetch_only_gnt", last_fg, 1'b1);
      end
      bus.fetch_req = 1'b0;
      check32("fetch_a2_data", bus.fetch_rdata, 32'hA2);
      tick();

      // Contention fairness over 10 cycles.
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 5'd5;
      bus.ld_req     = 1'b1;
      bus.ld_addr    = 5'd10;
      capture = 1'b1;
      for (int c = 0; c < 10; c++) tick();
      capture = 1'b0;
      n_tests++;
      assert (seq == "LLLLFLLLLF") else begin
         n_fail++;
         $error("FAIL grant_seq: observed %s expected LLLLFLLLLF", seq);
      end

      // Streak reaches the limit, then fetch drops: loader still granted.
      for (int c = 0; c < 4; c++) tick();
      bus.fetch_req = 1'b0;
      tick();
      check1("limit_drop_ld_gnt", last_lg, 1'b1);
      idle_inputs();
      tick();

      // Loader write then read of address 7.
      bus.ld_req   = 1'b1;
      bus.ld_we    = 1'b1;
      bus.ld_addr  = 5'd7;
      bus.ld_wdata = 32'hDEADBEEF;
      tick();
      bus.ld_we    = 1'b0;
      bus.ld_wdata = 32'd0;
      tick();
      bus.ld_req   = 1'b0;
      check32("ld_read_back", bus.ld_rdata, 32'hDEADBEEF);
      tick();

      // Kill the cycle after a fetch grant.
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 5'd3;
      tick();
      bus.fetch_kill = 1'b1;
      bus.fetch_addr = 5'd9;
      tick();
      idle_inputs();
      tick();

      // ld_hold starves fetch.
      bus.ld_hold    = 1'b1;
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 5'd4;
      for (int c = 0; c < 5; c++) tick();
      idle_inputs();
      tick();

      // Asynchronous reset pulse between the grant edge and the response edge.
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 5'd1;
      tick();
      bus.fetch_req = 1'b0;
      rst = 1'b1;
      model_reset();
      #1;
      check1("rst_pulse_rvalid", bus.fetch_rvalid, 1'b0);
      check1("rst_pulse_mem_en", bus.mem_en, 1'b0);
      rst = 1'b0;
      tick();
      tick();

      // Randomized traffic honouring the request hold rule.
      for (int i = 0; i < 400; i++) begin
         if (!(bus.fetch_req && !last_fg && !bus.fetch_kill)) begin
            bus.fetch_req  = ($urandom_range(0, 3) != 0);
            bus.fetch_addr = 5'($urandom);
         end
         if (!(bus.ld_req && !last_lg)) begin
            bus.ld_req   = ($urandom_range(0, 2) == 0);
            bus.ld_we    = 1'($urandom_range(0, 1));
            bus.ld_addr  = 5'($urandom);
            bus.ld_wdata = $urandom;
         end
         bus.fetch_kill = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 15) == 0) bus.ld_hold = !bus.ld_hold;
         tick();
      end
      idle_inputs();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Arbiter sharing the single-port instruction memory between the fetch stage and the program loader/debug port. One memory operation is issued per cycle and its response returns one cycle later, tagged to the requester that issued it. Loader priority is bounded by a fairness counter. The arbiter produces the fetch stall and honours branch flushes by suppressing wrong-path fetch responses.

## Interface
Parameters:
- ADDR_W, 5, word-address width (32-word memory; the PC steps by 1 per instruction)
- DATA_W, 32, data width
- MAX_LD_BURST, 4, maximum consecutive loader grants while fetch is waiting; legal range is 1 to 15

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- fetch_req  in  1  fetch wants a read this cycle
- fetch_addr  in  ADDR_W  fetch word address
- fetch_kill  in  1  branch taken (PCSrcD); flush fetch
- fetch_gnt  out  1  fetch op issued this cycle (combinational)
- stall_f  out  1  fetch_req & ~fetch_gnt & ~fetch_kill
- fetch_rvalid  out  1  fetch read data valid
- fetch_rdata  out  DATA_W  fetch read data
- ld_req  in  1  loader request
- ld_we  in  1  loader write (1) or read (0)
- ld_addr  in  ADDR_W  loader word address
- ld_wdata  in  DATA_W  loader write data
- ld_hold  in  1  loader owns the memory; fetch is never granted
- ld_gnt  out  1  loader op issued this cycle (combinational)
- ld_rvalid  out  1  loader response; pulses for both reads and writes
- ld_rdata  out  DATA_W  loader read data (0 for writes)
- mem_en, mem_we  out  1  memory strobe and write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en

## Operation
- **Grant decision** (combinational from inputs and registered state):
  - While rst is high, nothing is granted.
  - fetch_kill forces fetch_gnt=0, because the presented address is wrong-path.
  - ld_hold forces fetch_gnt=0.
  - If only one requester is eligible, it is granted.
  - If both are eligible, the loader wins unless streak==MAX_LD_BURST, in which case fetch wins.
- **Memory port:**
  - mem_en = fetch_gnt | ld_gnt.
  - mem_we = ld_gnt & ld_we.
  - mem_addr and mem_wdata are muxed from the granted requester.
  - When nothing is granted, the memory outputs are 0.
- **streak** is a 4-bit register:
  - It increments on a loader grant while fetch_req & ~ld_hold & ~fetch_kill.
  - It clears on a fetch grant, or in any cycle where fetch is not eligible.
  - It saturates at MAX_LD_BURST.
- **Owner register** holds the owner of the in-flight op: IDLE, FETCH, LD_RD or LD_WR.
  - It is loaded each cycle from the grant result.
  - With no grant it loads IDLE.
- **Response cycle:**
  - owner==FETCH gives fetch_rvalid=~fetch_kill and fetch_rdata=mem_rdata.
  - owner==LD_RD gives ld_rvalid=1 and ld_rdata=mem_rdata.
  - owner==LD_WR gives ld_rvalid=1 and ld_rdata=0.
  - Any rdata output whose rvalid is 0 is driven to 0.
- **Kill:** fetch_kill in the response cycle suppresses fetch_rvalid. The wrong-path instruction is dropped, so IF sees a bubble, matching the InstrD zeroing on PCSrcD.
- **Request hold rule:** a requester holds its request and address stable until it sees its gnt. After gnt it may change them on the next edge.

## Timing
- Issue-to-response latency is exactly 1 cycle. Throughput is 1 op per cycle. Back-to-back grants to different requesters are legal, and each response is steered by owner.
- **Reset:**
  - owner=IDLE and streak=0.
  - All gnt, rvalid, rdata and mem_* outputs are 0.
  - Asserting rst with an op in flight discards its response; no rvalid appears after rst deasserts.
- **Simultaneous fetch_kill and fetch_req:** no fetch grant. If ld_req is also present, the loader is granted regardless of streak.
- **ld_hold:** fetch is starved while it is high; stall_f stays high throughout. The streak counter stays 0.
- **streak at limit with fetch_req dropping:** streak clears and the loader is granted normally.

## Structure
- **Shared package (imem_pkg):**
  - owner enum: IDLE, FETCH, LD_RD, LD_WR.
  - Default ADDR_W and DATA_W constants, shared with instruction_memory and IF.
- **Module split:** single module, no sub-module. The streak counter and owner register are too small to split out.

## Test plan
- **Fetch only:** fetch_req=1 with addresses 0,1,2 on consecutive cycles, memory preloaded with 0xA0,0xA1,0xA2. Expect fetch_gnt every cycle, stall_f=0, and fetch_rvalid with rdata 0xA0,0xA1,0xA2 one cycle later.
- **Contention fairness (MAX_LD_BURST=4):** fetch_req and ld_req held high for 10 cycles. Expect grant sequence L,L,L,L,F,L,L,L,L,F, with stall_f high in the loader-granted cycles.
- **Loader write then read:** write 0xDEADBEEF to address 7, then read address 7. Expect ld_rvalid with rdata 0 for the write and 0xDEADBEEF for the read, each one cycle after its gnt.
- **Kill:** fetch is granted for address 3; fetch_kill=1 in the next cycle. Expect no fetch_rvalid, no fetch_gnt in the kill cycle, and stall_f=0 in the kill cycle.
- **ld_hold:** ld_hold=1 with fetch_req=1 and ld_req idle for 5 cycles. Expect fetch_gnt=0, stall_f=1 and mem_en=0 throughout.
- **Reset mid-op:** fetch is granted at cycle N; rst is pulsed asynchronously between the edges of N and N+1. Expect fetch_rvalid=0 at N+1, and all outputs 0 until the first post-reset grant.
